// File: rtl/ef_i2s_tdm_rx.sv
// I2S / left-justified / TDM master receiver: generates SCK and WS, deserialises SDI
// into right-justified, channel-tagged samples held in a first-word fall-through FIFO.
module ef_i2s_tdm_rx #(
  parameter int CH_MAX  = 8,
  parameter int FIFO_AW = 5,
  parameter int PW      = 8,
  localparam int CW     = $clog2(CH_MAX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PW-1:0]      sck_prescaler,
  input  logic               mode,
  input  logic [CW-1:0]      ch_count,
  input  logic [CH_MAX-1:0]  ch_enable,
  input  logic [4:0]         sample_size,
  input  logic               sign_extend,
  output logic               sck,
  output logic               ws,
  input  logic               sdi,
  input  logic               fifo_rd,
  output logic [31:0]        fifo_rdata,
  output logic [CW-1:0]      fifo_rch,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_level,
  input  logic [FIFO_AW:0]   fifo_threshold,
  output logic               fifo_level_above,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam int PSW   = CW + 5;
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [31:0]   data;
  } entry_t;

  // WS level for frame position p; 'last' is L-1, lj selects left-justified framing.
  function automatic logic ws_at(input logic [PSW-1:0] p, input logic [PSW-1:0] last,
                                 input logic lj, input logic st);
    logic [PSW-1:0] q;
    q = lj ? p : ((p == last) ? {PSW{1'b0}} : p + 1'b1);
    if (st) return lj ? (q < PSW'(32)) : (q >= PSW'(32));
    return q == {PSW{1'b0}};
  endfunction

  logic [PW-1:0]  presc;
  logic [PSW-1:0] pos;
  logic [31:0]    shreg;
  logic           armed;

  logic [CW-1:0]  nch;
  logic           stereo;
  logic [PSW-1:0] lm1, pos_nxt, q_cap;
  logic [4:0]     b;
  logic [CW-1:0]  s;
  logic           tick, rise, fall;
  logic [31:0]    sh_nxt, mask, smp;
  logic           push;

  assign nch     = (ch_count == '0) ? CW'(1) : ch_count;
  assign stereo  = (nch == CW'(1));
  assign lm1     = {nch, 5'h1f};
  assign pos_nxt = (pos == lm1) ? {PSW{1'b0}} : pos + 1'b1;

  assign tick = en && (presc == '0);
  assign rise = tick && !sck;
  assign fall = tick && sck;

  // I2S data lags the frame position by one bit period.
  assign q_cap = mode ? pos : ((pos == '0) ? lm1 : pos - 1'b1);
  assign b     = q_cap[4:0];
  assign s     = q_cap[PSW-1:5];

  assign sh_nxt = (b == 5'd0) ? {31'b0, sdi} : {shreg[30:0], sdi};
  assign mask   = 32'hffff_ffff >> (5'd31 - sample_size);
  assign smp    = (sign_extend && sh_nxt[sample_size]) ? (sh_nxt | ~mask) : (sh_nxt & mask);

  // A slot counts as complete when its MSB was captured in this enable session.
  assign push = rise && (b == sample_size) && ch_enable[s] && (armed || b == 5'd0);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      presc <= '0;
      sck   <= 1'b0;
      pos   <= '0;
      ws    <= ws_at({PSW{1'b0}}, lm1, mode, stereo);
      shreg <= '0;
      armed <= 1'b0;
    end else begin
      if (presc == '0) begin
        presc <= sck_prescaler;
        sck   <= ~sck;
      end else begin
        presc <= presc - 1'b1;
      end
      if (fall) begin
        pos <= pos_nxt;
        ws  <= ws_at(pos_nxt, lm1, mode, stereo);
      end
      if (rise) begin
        shreg <= sh_nxt;
        if (b == 5'd0) armed <= 1'b1;
      end
    end
  end

  entry_t             mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   level;
  logic               full, do_pop, do_push, drop;

  assign full    = (level == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = fifo_rd && (level != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      level   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= '{ch: s, data: smp};
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign fifo_rdata       = mem[rp].data;
  assign fifo_rch         = mem[rp].ch;
  assign fifo_empty       = (level == '0);
  assign fifo_full        = full;
  assign fifo_level       = level;
  assign fifo_level_above = (level > fifo_threshold);

endmodule

// File: tb/tb_ef_i2s_tdm_rx.sv
// Directed bench for ef_i2s_tdm_rx: a transmitter model drives SDI from slot words,
// SCK/WS are checked every cycle against arithmetic on elapsed clocks, FIFO against literals.
module tb_ef_i2s_tdm_rx;
  localparam int CH_MAX = 8, FIFO_AW = 2, PW = 8, CW = 3;

  logic clk = 0, rst = 1, en = 0;
  logic [PW-1:0] sck_prescaler = 1;
  logic mode = 0;
  logic [CW-1:0] ch_count = 1;
  logic [CH_MAX-1:0] ch_enable = 8'h03;
  logic [4:0] sample_size = 15;
  logic sign_extend = 1;
  logic sck, ws, sdi = 0, fifo_rd = 0;
  logic [31:0] fifo_rdata;
  logic [CW-1:0] fifo_rch;
  logic fifo_empty, fifo_full, fifo_level_above, overrun, overrun_clr = 0;
  logic [FIFO_AW:0] fifo_level, fifo_threshold = 3;

  int ncnt;
  logic [31:0] slot_word [CH_MAX];
  bit chk_on = 0;
  int n_assert = 0, n_fail = 0;
  logic [31:0] exp_d[$];
  int exp_c[$];

  ef_i2s_tdm_rx #(.CH_MAX(CH_MAX), .FIFO_AW(FIFO_AW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .sck_prescaler(sck_prescaler), .mode(mode),
    .ch_count(ch_count), .ch_enable(ch_enable), .sample_size(sample_size),
    .sign_extend(sign_extend), .sck(sck), .ws(ws), .sdi(sdi), .fifo_rd(fifo_rd),
    .fifo_rdata(fifo_rdata), .fifo_rch(fifo_rch), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .fifo_threshold(fifo_threshold),
    .fifo_level_above(fifo_level_above), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  // Enabled clock edges since the engine left idle.
  always @(posedge clk) if (rst || !en) ncnt <= 0; else ncnt <= ncnt + 1;

  function automatic int frame_len();
    int nch = (ch_count == 0) ? 1 : int'(ch_count);
    return 32 * (nch + 1);
  endfunction
  function automatic int half();
    return int'(sck_prescaler) + 1;
  endfunction
  function automatic bit sck_model(input int n);
    if (n == 0) return 1'b0;
    return ((n - 1) / half()) % 2 == 0;
  endfunction
  function automatic int pos_model(input int n);
    if (n == 0) return 0;
    return (((n - 1) / half() + 1) / 2) % frame_len();
  endfunction
  function automatic bit ws_model(input int p);
    int l = frame_len();
    int a = mode ? p : (p + 1) % l;
    if (l == 64) return mode ? (a < 32) : (a >= 32);
    return a == 0;
  endfunction

  // Transmitter: bit period t carries logical bit t (LJ) or t-1 (I2S) of the frame.
  always @(posedge clk) begin
    int t, q;
    #1;
    t = ncnt / (2 * half());
    q = mode ? t % frame_len() : (t + frame_len() - 1) % frame_len();
    sdi = slot_word[q / 32][31 - q % 32];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("sck", 32'(sck), 32'(sck_model(ncnt)));
      check("ws", 32'(ws), 32'(ws_model(pos_model(ncnt))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int p, input int md, input int cc, input logic [7:0] ce,
                           input int ss, input int se,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    chk_on = 0;
    en = 0;
    tick();
    sck_prescaler = PW'(p);
    mode = md[0];
    ch_count = CW'(cc);
    ch_enable = ce;
    sample_size = 5'(ss);
    sign_extend = se[0];
    for (int i = 0; i < CH_MAX; i++) slot_word[i] = 32'h0;
    slot_word[0] = w0; slot_word[1] = w1; slot_word[2] = w2; slot_word[3] = w3;
    repeat (2) tick();
    chk_on = 1;
  endtask

  task automatic run_periods(input int periods, input bit stop);
    int target = 2 * half() * periods;
    int guard = 0;
    en = 1;
    while (ncnt != target && guard < 20000) begin
      tick();
      guard++;
    end
    check("run_reach", 32'(ncnt), 32'(target));
    if (stop) en = 0;
  endtask

  task automatic expect_word(input logic [31:0] d, input int c);
    exp_d.push_back(d);
    exp_c.push_back(c);
  endtask

  task automatic drain();
    while (exp_d.size() > 0) begin
      @(negedge clk);
      check("level", 32'(fifo_level), 32'(exp_d.size()));
      check("not_empty", 32'(fifo_empty), 32'd0);
      check("rdata", fifo_rdata, exp_d[0]);
      check("rch", 32'(fifo_rch), 32'(exp_c[0]));
      void'(exp_d.pop_front());
      void'(exp_c.pop_front());
      tick();
      fifo_rd = 1;
      tick();
      fifo_rd = 0;
    end
    @(negedge clk);
    check("drained_empty", 32'(fifo_empty), 32'd1);
    check("drained_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < CH_MAX; i++) slot_word[i] = 32'h0;
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    tick();
    rst = 0;

    // Stereo I2S, 16-bit signed
    configure(1, 0, 1, 8'h03, 15, 1, 32'h8001_0000, 32'h1234_0000, 0, 0);
    fifo_threshold = 1;
    @(negedge clk);
    check("i2s_idle_ws", 32'(ws), 32'd0);
    run_periods(64, 1);
    @(negedge clk);
    check("t1_level", 32'(fifo_level), 32'd2);
    check("t1_above", 32'(fifo_level_above), 32'd1);
    check("t1_full", 32'(fifo_full), 32'd0);
    expect_word(32'hFFFF_8001, 0);
    expect_word(32'h0000_1234, 1);
    drain();

    // Stereo left-justified, same data
    configure(1, 1, 1, 8'h03, 15, 1, 32'h8001_0000, 32'h1234_0000, 0, 0);
    @(negedge clk);
    check("lj_idle_ws", 32'(ws), 32'd1);
    run_periods(64, 1);
    expect_word(32'hFFFF_8001, 0);
    expect_word(32'h0000_1234, 1);
    drain();

    // TDM 4 slots, slots 1 and 3 stored, 32-bit
    configure(1, 0, 3, 8'b1010, 31, 0, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    run_periods(129, 1);
    expect_word(32'hA000_0001, 1);
    expect_word(32'hA000_0003, 3);
    drain();

    // Three stereo frames into a 4-deep FIFO without reading
    configure(1, 0, 1, 8'h03, 15, 1, 32'h8001_0000, 32'h1234_0000, 0, 0);
    fifo_threshold = 3;
    run_periods(192, 1);
    @(negedge clk);
    check("t4_level", 32'(fifo_level), 32'd4);
    check("t4_full", 32'(fifo_full), 32'd1);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_above3", 32'(fifo_level_above), 32'd1);
    tick();
    fifo_threshold = 4;
    @(negedge clk);
    check("t4_above4", 32'(fifo_level_above), 32'd0);
    tick();
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    @(negedge clk);
    check("t4_overrun_clr", 32'(overrun), 32'd0);
    check("t4_level_kept", 32'(fifo_level), 32'd4);
    expect_word(32'hFFFF_8001, 0);
    expect_word(32'h0000_1234, 1);
    expect_word(32'hFFFF_8001, 0);
    expect_word(32'h0000_1234, 1);
    drain();
    tick();
    fifo_rd = 1;
    tick();
    fifo_rd = 0;
    @(negedge clk);
    check("pop_empty_level", 32'(fifo_level), 32'd0);
    check("pop_empty_flag", 32'(fifo_empty), 32'd1);

    // Disable mid-slot and restart; the wrapped first bit must not push a sample
    configure(1, 0, 1, 8'h03, 31, 1, 32'hCAFE_0001, 32'h5A5A_1234, 0, 0);
    run_periods(40, 1);
    repeat (10) tick();
    @(negedge clk);
    check("t5_sck_idle", 32'(sck), 32'd0);
    check("t5_level", 32'(fifo_level), 32'd1);
    run_periods(66, 1);
    expect_word(32'hCAFE_0001, 0);
    expect_word(32'hCAFE_0001, 0);
    expect_word(32'h5A5A_1234, 1);
    drain();

    // Reset mid-frame with three words held
    configure(1, 0, 1, 8'h03, 15, 1, 32'h8001_0000, 32'h1234_0000, 0, 0);
    run_periods(100, 0);
    @(negedge clk);
    check("t6_level_before", 32'(fifo_level), 32'd3);
    tick();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("t6_empty", 32'(fifo_empty), 32'd1);
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_sck", 32'(sck), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_full", 32'(fifo_full), 32'd0);
    tick();
    rst = 0;
    en = 0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
